aes_dec_iter: RTL and testbench
===============================

Name: aes_dec_iter

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 InvCipher): one round per clock.
- Decrypts a 128-bit ciphertext using the round-10 key (last encryption round key). Earlier round keys are regenerated on the fly by an inverse key schedule.
- Decrypt-direction counterpart to the HEA encryption datapath. Reuses shift_rows and mix_columns with OP=1'b0.
- Sits behind the accelerator's command interface with valid/ready on input and output.

Parameters:
- ZEROIZE, 1: when 1, internal state and key registers clear to 0 on the DONE->IDLE transition.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- in_valid_i  in  1  ciphertext/key offered
- in_ready_o  out  1  core can accept; high only in IDLE
- ct_i  in  128  ciphertext; byte 0 = [127:120], column-major per FIPS-197
- key_i  in  128  round-10 key (w[40..43]), same byte order
- out_valid_o  out  1  plaintext valid
- out_ready_i  in  1  consumer accepts plaintext
- pt_o  out  128  plaintext

Behaviour:
- Reset values: in_ready_o=1, out_valid_o=0, pt_o=0. State=IDLE, round counter=0, state and key registers=0.
- Reset mid-operation: the round in progress is abandoned with no output; the next cycle is IDLE.
- FSM IDLE -> ROUND -> DONE -> IDLE.
- IDLE:
  - Accept when in_valid_i & in_ready_o.
  - On accept: st <= ct_i ^ key_i; rk <= key_i; rnd <= 9; go to ROUND.
- ROUND, rnd = 9..0, one per cycle:
  - rk_n = inv_key_step(rk, rcon[rnd+1]).
  - t = InvSubBytes(InvShiftRows(st)) ^ rk_n.
  - st <= (rnd==0) ? t : InvMixColumns(t); rk <= rk_n.
  - rnd==0: go to DONE and load pt_o <= t.
  - Otherwise rnd <= rnd-1.
- Latency: accept edge E0; rounds on edges E1..E10; out_valid_o high from E10 onward (10 cycles after accept).
- DONE:
  - out_valid_o=1; pt_o stable until handshake.
  - On out_ready_i: out_valid_o <= 0; go to IDLE.
  - in_ready_o=0 throughout ROUND and DONE. Exactly one transaction in flight; no overlap of output drain and new accept.
  - Back-pressure: DONE may hold indefinitely; inputs are ignored while in_ready_o=0.
- pt_o keeps its last value after the handshake, unless ZEROIZE=1, in which case pt_o, st and rk clear to 0.
- inv_key_step, words w0..w3 of rk, producing p0..p3:
  - p3=w3^w2; p2=w2^w1; p1=w1^w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon,24'h0}.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Arithmetic: all GF(2^8); InvMixColumns coefficients 0e,0b,0d,09; no carries or width growth.

Decomposition:
- Package aes_pkg holds:
  - forward and inverse S-box functions or constant tables
  - rcon table (10 x 8 bit)
  - state enum {IDLE, ROUND, DONE}
  - 4-bit round counter type
  - byte and word helpers (get_byte, SubWord, RotWord)
- One sub-module: aes_inv_key_step (combinational, 128-bit in, rcon in, 128-bit out). It is reusable by a future key-unwrap path.
- InvShiftRows and InvMixColumns come from the existing shift_rows and mix_columns instances with OP=1'b0. InvSubBytes is 16 inverse-S-box lookups in the top.

Test Plan:
- FIPS-197 C.1: ct=69c4e0d86a7b0430d8cdb78070b4c55a, key_i=13111d7fe3944a17f307a78b4d2b30c5 -> pt_o=00112233445566778899aabbccddeeff. out_valid_o rises 10 cycles after the accept edge.
- FIPS-197 App. B: ct=3925841d02dc09fbdc118597196a0b32, key_i=d014f9a8c9ee2589e13f0cc8b6630ca6 -> pt_o=3243f6a8885a308d313198a2e0370734.
- Back-pressure: hold out_ready_i=0 for 20 cycles after valid. pt_o and out_valid_o stay stable, in_ready_o=0, a second in_valid_i is ignored. Release -> handshake, in_ready_o=1 the next cycle.
- Reset at round 5: rst_i high one cycle -> out_valid_o never asserts, in_ready_o=1 after reset. A new C.1 vector then decrypts correctly.
- Back-to-back: C.1 then App. B, with out_ready_i tied 1 and in_valid_i held high -> two correct outputs, each one cycle wide. The second accept happens the cycle after the first output handshake.
- ZEROIZE=1: after a handshake, internal st/rk probes and pt_o read 0. With ZEROIZE=0, pt_o retains the last plaintext.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the iterative inverse-cipher core.
// Contents: FSM state constants, round counter type, rcon table, GF(2^8)
// arithmetic, forward/inverse S-box functions and byte/word helpers.
// No ports. Other files pull it in with import aes_pkg::*.
package aes_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef logic [3:0] rnd_t;

  // rcon[1] sits in the top byte, rcon[10] in the bottom byte.
  localparam logic [79:0] RCON_TABLE = 80'h01020408102040801b36;

  function automatic logic [7:0] get_rcon(input rnd_t i);
    if (i >= 4'd1 && i <= 4'd10) return RCON_TABLE[(10 - int'(i))*8 +: 8];
    return 8'h00;
  endfunction

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2*a^4*...*a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] base;
    r    = 8'h01;
    base = a;
    for (int i = 1; i < 8; i++) begin
      base = gf_mul(base, base);
      r    = gf_mul(r, base);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  // Undo the affine map first, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // Byte 0 is the most significant byte of the 128-bit block.
  function automatic logic [7:0] get_byte(input logic [127:0] w, input int i);
    return w[127-8*i -: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_dec_iter_if.sv
// aes_dec_iter_if: command-side bundle of the AES decrypt core.
// Input channel : in_valid_i, in_ready_o, ct_i[127:0], key_i[127:0]
// Output channel: out_valid_o, out_ready_i, pt_o[127:0]
// master = requester/consumer side, slave = the core.
interface aes_dec_iter_if;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] ct_i;
  logic [127:0] key_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] pt_o;

  modport master (output in_valid_i, ct_i, key_i, out_ready_i,
                  input  in_ready_o, out_valid_o, pt_o);
  modport slave  (input  in_valid_i, ct_i, key_i, out_ready_i,
                  output in_ready_o, out_valid_o, pt_o);
endinterface

// File: rtl/aes_inv_key_step.sv
// aes_inv_key_step: one step backwards through the AES-128 key schedule.
// Ports: rk_i[127:0] round key i, rcon_i[7:0] rcon of round i,
//        rk_o[127:0] round key i-1. Purely combinational.
module aes_inv_key_step import aes_pkg::*; (
  input  logic [127:0] rk_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] rk_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;

  assign {w0, w1, w2, w3} = rk_i;

  // p3 is the previous key's last word, which fed the g() function that
  // produced w0, so it recovers p0.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign p0 = w0 ^ sub_word(rot_word(p3)) ^ {rcon_i, 24'h0};

  assign rk_o = {p0, p1, p2, p3};

endmodule

// File: rtl/mix_columns.sv
// mix_columns: AES MixColumns (OP=1) or InvMixColumns (OP=0), combinational.
// Ports: in_i[127:0] state in, out_o[127:0] state out (column-major bytes).
module mix_columns import aes_pkg::*; #(
  parameter logic OP = 1'b1
) (
  input  logic [127:0] in_i,
  output logic [127:0] out_o
);

  // First row of the circulant matrix; row r is this rotated right by r.
  localparam logic [31:0] COEF = OP ? 32'h02030101 : 32'h0e0b0d09;

  always_comb begin
    out_o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        for (int k = 0; k < 4; k++) begin
          out_o[127-8*(4*c+r) -: 8] = out_o[127-8*(4*c+r) -: 8] ^
            gf_mul(COEF[31-8*((k-r+4)%4) -: 8], in_i[127-8*(4*c+k) -: 8]);
        end
      end
    end
  end

endmodule

// File: rtl/shift_rows.sv
// shift_rows: AES ShiftRows (OP=1) or InvShiftRows (OP=0), combinational.
// Ports: in_i[127:0] state in, out_o[127:0] state out (column-major bytes).
module shift_rows #(
  parameter logic OP = 1'b1
) (
  input  logic [127:0] in_i,
  output logic [127:0] out_o
);

  // Byte index is 4*column+row; row r rotates left (forward) or right
  // (inverse) by r columns.
  always_comb begin
    out_o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        out_o[127-8*(4*c+r) -: 8] =
          in_i[127-8*(4*(OP ? (c+r)%4 : (c+4-r)%4)+r) -: 8];
      end
    end
  end

endmodule

// File: rtl/aes_dec_iter.sv
// aes_dec_iter: iterative AES-128 inverse cipher, one round per clock.
// Ports: clk_i clock, rst_i synchronous active-high reset,
//        bus (aes_dec_iter_if.slave): ct_i/key_i in with in_valid_i/in_ready_o,
//        pt_o out with out_valid_o/out_ready_i. key_i is the round-10 key.
// Parameter ZEROIZE: clear st, rk and pt_o when the plaintext is taken.
module aes_dec_iter import aes_pkg::*; #(
  parameter logic ZEROIZE = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  aes_dec_iter_if.slave  bus
);

  logic [1:0]   state;
  rnd_t         rnd;
  logic [127:0] st;
  logic [127:0] rk;
  logic [127:0] pt;

  logic [7:0]   rcon;
  logic [127:0] rk_n;
  logic [127:0] isr;
  logic [127:0] isb;
  logic [127:0] t;
  logic [127:0] imc;

  // rnd counts 9..0 while the key walks from round 10 down to round 0.
  assign rcon = get_rcon(rnd + 4'd1);

  aes_inv_key_step u_key_step (
    .rk_i   (rk),
    .rcon_i (rcon),
    .rk_o   (rk_n)
  );

  shift_rows #(.OP(1'b0)) u_inv_shift_rows (
    .in_i  (st),
    .out_o (isr)
  );

  always_comb begin
    isb = '0;
    for (int i = 0; i < 16; i++) begin
      isb[127-8*i -: 8] = inv_sbox(get_byte(isr, i));
    end
  end

  assign t = isb ^ rk_n;

  mix_columns #(.OP(1'b0)) u_inv_mix_columns (
    .in_i  (t),
    .out_o (imc)
  );

  assign bus.in_ready_o  = (state == IDLE);
  assign bus.out_valid_o = (state == DONE);
  assign bus.pt_o        = pt;

  // The last round skips InvMixColumns and also loads the plaintext.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      rnd   <= '0;
      st    <= '0;
      rk    <= '0;
      pt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid_i) begin
            st    <= bus.ct_i ^ bus.key_i;
            rk    <= bus.key_i;
            rnd   <= 4'd9;
            state <= ROUND;
          end
        end
        ROUND: begin
          rk <= rk_n;
          if (rnd == 4'd0) begin
            st    <= t;
            pt    <= t;
            state <= DONE;
          end else begin
            st  <= imc;
            rnd <= rnd - 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            state <= IDLE;
            if (ZEROIZE) begin
              st <= '0;
              rk <= '0;
              pt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_iter.sv
// tb_aes_dec_iter: self-checking bench for aes_dec_iter. Two instances run
// the same traffic: dut (ZEROIZE=1) and dut_keep (ZEROIZE=0). Expected
// plaintexts come from FIPS-197 constants and from a byte-array reference
// decryptor that rebuilds the full key schedule from the round-10 key.
module tb_aes_dec_iter;

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  always #5 clk = ~clk;

  aes_dec_iter_if bus ();
  aes_dec_iter_if bus_k ();

  assign bus_k.in_valid_i  = bus.in_valid_i;
  assign bus_k.ct_i        = bus.ct_i;
  assign bus_k.key_i       = bus.key_i;
  assign bus_k.out_ready_i = bus.out_ready_i;

  aes_dec_iter #(.ZEROIZE(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  aes_dec_iter #(.ZEROIZE(1'b0)) dut_keep (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_k)
  );

  // Reference model helpers
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  // Walk the generator 3 and its inverse together to fill the S-box.
  task automatic buildTables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = i[7:0];
  endtask

  function automatic logic [127:0] modelDecrypt(input logic [127:0] ct, input logic [127:0] k10);
    logic [31:0]  w  [44];
    logic [7:0]   rc [11];
    logic [7:0]   s  [16];
    logic [7:0]   u  [16];
    logic [31:0]  tmp;
    logic [127:0] res;
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rc[i] = xt(rc[i-1]);
    for (int i = 0; i < 4; i++) w[40+i] = k10[127-32*i -: 32];
    for (int i = 39; i >= 0; i--) begin
      tmp = w[i+3];
      if ((i + 4) % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc[(i+4)/4], 24'h0};
      end
      w[i] = w[i+4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = ct[127-8*b -: 8] ^ w[40 + b/4][31-8*(b%4) -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          u[4*((c+r)%4)+r] = isb[s[4*c+r]];
      for (int b = 0; b < 16; b++) u[b] = u[b] ^ w[4*rd + b/4][31-8*(b%4) -: 8];
      if (rd > 0) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c+0] = gm(u[4*c], 8'h0e) ^ gm(u[4*c+1], 8'h0b) ^ gm(u[4*c+2], 8'h0d) ^ gm(u[4*c+3], 8'h09);
          s[4*c+1] = gm(u[4*c], 8'h09) ^ gm(u[4*c+1], 8'h0e) ^ gm(u[4*c+2], 8'h0b) ^ gm(u[4*c+3], 8'h0d);
          s[4*c+2] = gm(u[4*c], 8'h0d) ^ gm(u[4*c+1], 8'h09) ^ gm(u[4*c+2], 8'h0e) ^ gm(u[4*c+3], 8'h0b);
          s[4*c+3] = gm(u[4*c], 8'h0b) ^ gm(u[4*c+1], 8'h0d) ^ gm(u[4*c+2], 8'h09) ^ gm(u[4*c+3], 8'h0e);
        end
      end else begin
        for (int b = 0; b < 16; b++) s[b] = u[b];
      end
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Waits (bounded) for in_ready, offers one block for exactly one edge,
  // returns on the negedge right after the accept edge.
  task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] key);
    int n;
    n = 0;
    while (bus.in_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready before offer", 128'(bus.in_ready_o), 128'd1);
    bus.in_valid_i = 1'b1;
    bus.ct_i       = ct;
    bus.key_i      = key;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic waitOutput(output int cycles);
    cycles = 0;
    while (bus.out_valid_o !== 1'b1 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("out_valid seen", 128'(bus.out_valid_o), 128'd1);
  endtask

  task automatic runTxn(input string tag, input logic [127:0] ct, input logic [127:0] key,
                        input logic [127:0] expected, input int hold);
    int cyc;
    applyStimulus(ct, key);
    waitOutput(cyc);
    checkOutput($sformatf("%s latency", tag), 128'(cyc), 128'd10);
    repeat (hold) @(negedge clk);
    checkOutput($sformatf("%s pt", tag), bus.pt_o, expected);
    checkOutput($sformatf("%s pt keep", tag), bus_k.pt_o, expected);
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    checkOutput($sformatf("%s out_valid drop", tag), 128'(bus.out_valid_o), 128'd0);
    checkOutput($sformatf("%s in_ready back", tag), 128'(bus.in_ready_o), 128'd1);
    checkOutput($sformatf("%s pt zeroized", tag), bus.pt_o, 128'd0);
    checkOutput($sformatf("%s pt retained", tag), bus_k.pt_o, expected);
  endtask

  initial begin
    int          cyc;
    logic        seen;
    logic [127:0] rct, rkey;
    logic        ov [24];
    logic        ir [24];
    logic [127:0] pq [24];
    int          outs;
    int          first_idx, second_idx;

    buildTables();
    rst             = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.ct_i        = '0;
    bus.key_i       = '0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", 128'(bus.in_ready_o), 128'd1);
    checkOutput("reset out_valid", 128'(bus.out_valid_o), 128'd0);
    checkOutput("reset pt", bus.pt_o, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    runTxn("C1", C1_CT, C1_KEY, C1_PT, 0);
    runTxn("AppB", B_CT, B_KEY, B_PT, 2);
    checkOutput("zeroize st", dut.st, 128'd0);
    checkOutput("zeroize rk", dut.rk, 128'd0);

    // Back-pressure with a competing offer that must be ignored
    applyStimulus(C1_CT, C1_KEY);
    waitOutput(cyc);
    bus.in_valid_i = 1'b1;
    bus.ct_i       = B_CT;
    bus.key_i      = B_KEY;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("bp out_valid", 128'(bus.out_valid_o), 128'd1);
      checkOutput("bp in_ready", 128'(bus.in_ready_o), 128'd0);
      checkOutput("bp pt", bus.pt_o, C1_PT);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    checkOutput("bp release out_valid", 128'(bus.out_valid_o), 128'd0);
    checkOutput("bp release in_ready", 128'(bus.in_ready_o), 128'd1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | bus.out_valid_o;
    end
    checkOutput("bp no ghost output", 128'(seen), 128'd0);

    // Reset in the middle of the rounds
    applyStimulus(C1_CT, C1_KEY);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset in_ready", 128'(bus.in_ready_o), 128'd1);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen = seen | bus.out_valid_o;
    end
    checkOutput("midreset no output", 128'(seen), 128'd0);
    runTxn("C1 after reset", C1_CT, C1_KEY, C1_PT, 1);

    // Back-to-back with in_valid held and out_ready tied high
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.ct_i        = C1_CT;
    bus.key_i       = C1_KEY;
    @(negedge clk);
    bus.ct_i  = B_CT;
    bus.key_i = B_KEY;
    for (int i = 0; i < 24; i++) begin
      ov[i] = bus.out_valid_o;
      ir[i] = bus.in_ready_o;
      pq[i] = bus.pt_o;
      if (i < 23) @(negedge clk);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    outs       = 0;
    first_idx  = -1;
    second_idx = -1;
    for (int i = 0; i < 24; i++) begin
      if (ov[i] === 1'b1) begin
        outs++;
        if (first_idx < 0) first_idx = i;
        else if (second_idx < 0) second_idx = i;
      end
    end
    checkOutput("b2b output count", 128'(outs), 128'd2);
    checkOutput("b2b first index", 128'(first_idx), 128'd10);
    checkOutput("b2b second index", 128'(second_idx), 128'd22);
    checkOutput("b2b first pt", pq[10], C1_PT);
    checkOutput("b2b second pt", pq[22], B_PT);
    checkOutput("b2b ready after first", 128'(ir[11]), 128'd1);
    checkOutput("b2b busy after second accept", 128'(ir[12]), 128'd0);
    checkOutput("b2b ready after second", 128'(ir[23]), 128'd1);
    @(negedge clk);

    // Random blocks against the reference model
    for (int n = 0; n < 6; n++) begin
      rct  = {$urandom, $urandom, $urandom, $urandom};
      rkey = {$urandom, $urandom, $urandom, $urandom};
      runTxn($sformatf("rand%0d", n), rct, rkey, modelDecrypt(rct, rkey), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
